// File: rtl/checkbits_driver_if.sv
// rtl/checkbits_driver_if.sv - Wishbone classic slave bundle for checkbits_driver
//
// Purpose: groups the Wishbone classic slave signals so the bus is a single port.
// Signals:
//   wbs_cyc_i, wbs_stb_i, wbs_we_i  cycle, strobe, write enable (master -> slave)
//   wbs_sel_i[3:0]                  byte selects (master -> slave)
//   wbs_adr_i[31:0]                 byte address (master -> slave)
//   wbs_dat_i[31:0]                 write data (master -> slave)
//   wbs_ack_o                       acknowledge (slave -> master)
//   wbs_dat_o[31:0]                 read data (slave -> master)
interface checkbits_driver_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/checkbits_driver.sv
// rtl/checkbits_driver.sv - Wishbone-programmed checkpoint code FIFO driving mprj_io[31:16]
//
// Purpose: software pushes 16-bit checkpoint codes into a FIFO; a two-state
// display FSM pops each code onto check_out and holds it for max(HOLD,1)+1
// cycles when codes are back-to-back.
// Ports:
//   wb_clk_i          sole clock, rising edge
//   resetb            synchronous active-low reset
//   wbs               Wishbone classic slave (checkbits_driver_if.slave)
//   check_out[15:0]   current checkpoint code
//   check_oeb[15:0]   active-low output enables, all bits equal to !EN
// Registers (offset from BASE_ADR): 0x00 CODE, 0x04 HOLD, 0x08 CTRL, 0x0C STATUS.
module checkbits_driver #(
    parameter logic [31:0] BASE_ADR   = 32'h3000_0000,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [15:0] HOLD_RST   = 16'd1000
) (
    input  logic                     wb_clk_i,
    input  logic                     resetb,
    checkbits_driver_if.slave        wbs,
    output logic [15:0]              check_out,
    output logic [15:0]              check_oeb
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [15:0]        check_out_q, check_out_d;
    logic [15:0]        hold_q, hold_d;
    logic               en_q, en_d;
    logic               ovf_q, ovf_d;
    logic               ack_q, ack_d;
    logic [31:0]        dat_q, dat_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [15:0]        mem_q [FIFO_DEPTH];

    logic               hit;
    logic [5:0]         reg_idx;
    logic               push_en;
    logic               pop_en;
    logic               flush;
    logic               fifo_full;
    logic               fifo_empty;
    logic [31:0]        status;
    logic [31:0]        rdata;
    logic               unused_bits;

    // Low address bits, byte selects and upper data bits carry no meaning here.
    assign unused_bits = ^{wbs.wbs_sel_i, wbs.wbs_adr_i[1:0], wbs.wbs_dat_i[31:16]};

    assign fifo_full  = (count_q == CNT_FULL);
    assign fifo_empty = (count_q == '0);
    assign reg_idx    = wbs.wbs_adr_i[7:2];

    // !ack_q blocks a second ack on the cycle right after one, so a master
    // holding stb across the ack edge is not acknowledged twice.
    assign hit = wbs.wbs_cyc_i && wbs.wbs_stb_i && !ack_q &&
                 (wbs.wbs_adr_i[31:8] == BASE_ADR[31:8]);

    always_comb begin
        status = '0;
        status[CNT_W-1:0] = count_q;
        status[8]  = fifo_empty;
        status[9]  = fifo_full;
        status[10] = (state_q == ST_HOLD);
        status[11] = ovf_q;
    end

    always_comb begin
        rdata = '0;
        case (reg_idx)
            6'd0:    rdata = {16'h0000, check_out_q};
            6'd1:    rdata = {16'h0000, hold_q};
            6'd2:    rdata = {31'h0, en_q};
            6'd3:    rdata = status;
            default: rdata = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        check_out_d = check_out_q;
        hold_d      = hold_q;
        en_d        = en_q;
        ovf_d       = ovf_q;
        ack_d       = 1'b0;
        dat_d       = '0;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        push_en     = 1'b0;
        flush       = 1'b0;

        // Bus access: every side effect lands on the edge that raises ack.
        if (hit) begin
            ack_d = 1'b1;
            if (!wbs.wbs_we_i) begin
                dat_d = rdata;
            end else begin
                case (reg_idx)
                    6'd0: begin
                        // Fullness is judged before this edge's pop, so a
                        // push into a full FIFO is dropped even if a slot frees.
                        if (fifo_full) ovf_d = 1'b1;
                        else           push_en = 1'b1;
                    end
                    6'd1: hold_d = wbs.wbs_dat_i[15:0];
                    6'd2: begin
                        en_d  = wbs.wbs_dat_i[0];
                        flush = wbs.wbs_dat_i[1];
                    end
                    6'd3: if (wbs.wbs_dat_i[11]) ovf_d = 1'b0;
                    default: ;
                endcase
            end
        end

        pop_en = (state_q == ST_IDLE) && !fifo_empty && !flush;

        case (state_q)
            ST_IDLE: begin
                if (pop_en) begin
                    check_out_d = mem_q[rd_ptr_q];
                    cnt_d       = (hold_q == 16'd0) ? 16'd0 : hold_q - 16'd1;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 16'd0) state_d = ST_IDLE;
                else                cnt_d   = cnt_q - 16'd1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (push_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Flush drops queued codes and aborts the hold but leaves check_out alone.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            state_d  = ST_IDLE;
            cnt_d    = 16'd0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!resetb) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 16'd0;
            check_out_q <= 16'd0;
            hold_q      <= HOLD_RST;
            en_q        <= 1'b0;
            ovf_q       <= 1'b0;
            ack_q       <= 1'b0;
            dat_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            check_out_q <= check_out_d;
            hold_q      <= hold_d;
            en_q        <= en_d;
            ovf_q       <= ovf_d;
            ack_q       <= ack_d;
            dat_q       <= dat_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Storage needs no reset: count_q alone decides which entries are live.
    always_ff @(posedge wb_clk_i) begin
        if (resetb && push_en) mem_q[wr_ptr_q] <= wbs.wbs_dat_i[15:0];
    end

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = dat_q;
    assign check_out     = check_out_q;
    assign check_oeb     = en_q ? 16'h0000 : 16'hFFFF;

endmodule
